// File: rtl/rxn_pkg.sv
// Shared types and constants for the reaction-game timing blocks.
package rxn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DANGER = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [10:0] GAME_OP   = 11'b00100000000;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam int          TICK_DIV  = 100000;

  // Right-shifting Galois step; the tap mask keeps the sequence maximal-length.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/rxn_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every clock, reloads SEED on reset.
module rxn_lfsr16 #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [15:0] state
);
  import rxn_pkg::*;

  logic [15:0] state_q;
  logic [15:0] state_d;

  always_comb begin
    state_d = lfsr_step(state_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/rxn_danger_timer.sv
// Random-delay danger generator for the reaction game: waits a random number
// of ms, raises danger, and flags false starts and timeouts.
module rxn_danger_timer #(
  parameter int          TICK_DIV   = rxn_pkg::TICK_DIV,
  parameter int          MIN_MS     = 1000,
  parameter int          RANGE_BITS = 12,
  parameter int          TIMEOUT_MS = 5000,
  parameter logic [10:0] GAME_OP    = rxn_pkg::GAME_OP,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op_code,
  input  logic        hit,
  output logic        danger,
  output logic        early,
  output logic        timeout,
  output logic [15:0] delay_ms,
  output logic [1:0]  state
);
  import rxn_pkg::*;

  localparam int          PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [15:0] RANGE_MASK = 16'((1 << RANGE_BITS) - 1);

  if (RANGE_BITS < 1 || RANGE_BITS > 15 ||
      MIN_MS + (1 << RANGE_BITS) - 1 > 65535) begin : g_bad_params
    $error("rxn_danger_timer: MIN_MS/RANGE_BITS do not fit a 16-bit delay");
  end

  state_e        state_q, state_d;
  logic          danger_q, danger_d;
  logic          early_q, early_d;
  logic          timeout_q, timeout_d;
  logic [15:0]   delay_q, delay_d;
  logic [15:0]   ms_cnt_q, ms_cnt_d;
  logic [15:0]   to_cnt_q, to_cnt_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [1:0]    sync_q, sync_d;

  logic [15:0] lfsr_state;
  logic [15:0] draw;
  logic        sel;
  logic        hit_s;
  logic        tick;

  rxn_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (lfsr_state)
  );

  assign sel   = (op_code == GAME_OP);
  assign hit_s = sync_q[1];
  assign draw  = 16'(MIN_MS) + (lfsr_state & RANGE_MASK);
  assign tick  = ((state_q == WAIT) || (state_q == DANGER)) && (presc_q == PRESC_MAX);

  always_comb begin
    state_d   = state_q;
    danger_d  = danger_q;
    early_d   = early_q;
    timeout_d = timeout_q;
    delay_d   = delay_q;
    ms_cnt_d  = ms_cnt_q;
    to_cnt_d  = to_cnt_q;
    presc_d   = presc_q;
    sync_d    = {sync_q[0], hit};

    if (!sel) begin
      state_d  = IDLE;
      danger_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          delay_d   = draw;
          ms_cnt_d  = draw;
          presc_d   = '0;
          early_d   = 1'b0;
          timeout_d = 1'b0;
          danger_d  = 1'b0;
          state_d   = WAIT;
        end
        WAIT: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          // A hit beats a tick that would expire the delay in the same cycle.
          if (hit_s) begin
            early_d = 1'b1;
            state_d = DONE;
          end else if (tick) begin
            ms_cnt_d = ms_cnt_q - 16'd1;
            if (ms_cnt_q == 16'd1) begin
              state_d  = DANGER;
              danger_d = 1'b1;
              to_cnt_d = 16'(TIMEOUT_MS);
              presc_d  = '0;
            end
          end
        end
        DANGER: begin
          presc_d = tick ? '0 : presc_q + 1'b1;
          // A valid hit leaves danger high so the game top sees the fixed condition.
          if (hit_s) begin
            state_d = DONE;
          end else if (tick) begin
            to_cnt_d = to_cnt_q - 16'd1;
            if (to_cnt_q == 16'd1) begin
              timeout_d = 1'b1;
              danger_d  = 1'b0;
              state_d   = DONE;
            end
          end
        end
        default: begin
          state_d = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      danger_q  <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      delay_q   <= '0;
      ms_cnt_q  <= '0;
      to_cnt_q  <= '0;
      presc_q   <= '0;
      sync_q    <= '0;
    end else begin
      state_q   <= state_d;
      danger_q  <= danger_d;
      early_q   <= early_d;
      timeout_q <= timeout_d;
      delay_q   <= delay_d;
      ms_cnt_q  <= ms_cnt_d;
      to_cnt_q  <= to_cnt_d;
      presc_q   <= presc_d;
      sync_q    <= sync_d;
    end
  end

  assign danger   = danger_q;
  assign early    = early_q;
  assign timeout  = timeout_q;
  assign delay_ms = delay_q;
  assign state    = state_q;

endmodule

// File: doc/rxn_danger_timer.md
Name: rxn_danger_timer

Overview:
- Upstream stage of the reaction-game top. Produces the `danger` level that drives the smile/pirate/disco selection and the stopwatch reset.
- Flow: when the game opcode is selected, draw a pseudo-random delay from a free-running LFSR and count it down in millisecond ticks. Then assert `danger` and hold it until the player hits, a timeout expires, or the opcode is deselected.
- Also flags false starts (a hit before `danger`) and timeouts.

Parameters:
- TICK_DIV, 100000: clk cycles per 1 ms tick (100 MHz clock).
- MIN_MS, 1000: minimum delay in ms.
- RANGE_BITS, 12: random span; delay = MIN_MS + lfsr[RANGE_BITS-1:0]. Legal range 1..15.
- TIMEOUT_MS, 5000: ms that `danger` may stay high without a hit.
- GAME_OP, 11'b00100000000: opcode value that arms the game.
- LFSR_SEED, 16'hACE1: nonzero LFSR reset value.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- op_code  in  11  one-hot opcode bus.
- hit  in  1  player input (OR of the switch bus). Asynchronous to game timing.
- danger  out  1  danger level consumed by the game top.
- early  out  1  sticky flag: hit seen before `danger`.
- timeout  out  1  sticky flag: no hit within TIMEOUT_MS.
- delay_ms  out  16  delay drawn for the current round (debug/display).
- state  out  2  current FSM state encoding.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset: state=IDLE; danger=0, early=0, timeout=0, delay_ms=0; LFSR=LFSR_SEED; prescaler and counters cleared.
- LFSR: 16-bit Galois, tap mask 16'hB400. Advances every clk, including during WAIT and DANGER. Never reaches zero.
- hit synchronizer: hit passes through a 2-FF synchronizer (hit_s). All decisions use hit_s, which adds 2 cycles of latency.
- sel: sel = (op_code == GAME_OP).
- Priority, highest first: reset; then !sel (next state IDLE, danger=0, flags retained); then the per-state rules below.
- IDLE:
  - danger=0.
  - If sel: load delay_ms = MIN_MS + lfsr[RANGE_BITS-1:0] using the LFSR value in this cycle.
  - Also on sel: load the ms counter with delay_ms, clear prescaler, clear early and timeout, and go to WAIT.
- Tick: the prescaler counts 0..TICK_DIV-1 while in WAIT or DANGER. tick=1 when prescaler==TICK_DIV-1, then the prescaler wraps to 0.
- WAIT:
  - If hit_s: early=1, go to DONE, danger stays 0. A hit wins over a tick that expires in the same cycle.
  - Else on tick: decrement the ms counter. If the counter was 1, go to DANGER, load the timeout counter with TIMEOUT_MS, and clear the prescaler.
  - Timing: danger rises exactly delay_ms*TICK_DIV+1 cycles after the IDLE cycle that sampled sel.
- DANGER:
  - danger=1.
  - If hit_s: go to DONE with danger held at 1 (the "fixed" condition in the game top). A hit wins over a timeout in the same cycle.
  - Else on tick: decrement the timeout counter. At expiry: timeout=1, danger=0, go to DONE.
- DONE:
  - Outputs frozen.
  - Stay in DONE while sel. Re-arming requires sel to drop (return to IDLE) and then reassert.
- hit_s held high at arm: early is flagged on the first WAIT cycle. A stuck switch must not yield a valid round.
- Reset mid-round: behaves as power-up reset; any pending danger clears on the next edge.
- Width rule: MIN_MS + 2^RANGE_BITS - 1 must not exceed 65535. Checked by an elaboration-time assertion.
- State encoding: IDLE=0, WAIT=1, DANGER=2, DONE=3.

Decomposition:
- Shared package rxn_pkg holds:
  - the state enum (IDLE/WAIT/DANGER/DONE);
  - GAME_OP;
  - the LFSR tap mask 16'hB400;
  - the default TICK_DIV.
- One sub-module, rxn_lfsr16: clk, reset, seed parameter, 16-bit state output. It is reusable by other pattern generators in the design.
- The synchronizer, prescaler and FSM live in rxn_danger_timer.

Test Plan (TICK_DIV=4, MIN_MS=2, RANGE_BITS=3, TIMEOUT_MS=5):
- Arm, no hit. Set op_code=GAME_OP for 1 cycle in IDLE and hold it.
  - delay_ms must be in 2..9 and match the bench LFSR model.
  - danger rises exactly delay_ms*4+1 cycles after arm.
  - danger falls after 20 more cycles with timeout=1.
- Normal hit. Pulse hit 3 cycles after danger rises.
  - DONE is entered 2 cycles after the pulse; danger stays 1, early=0, timeout=0.
- False start. Assert hit during WAIT.
  - early=1 and state=DONE 2 cycles later; danger never rises.
  - Also place hit_s on the final expiring tick: early must win.
- Deselect. Set op_code=0 mid-WAIT and again mid-DANGER.
  - Next cycle: state=IDLE, danger=0.
  - Reasserting GAME_OP re-arms with a fresh delay_ms and cleared flags.
- Reset mid-DANGER. Assert reset for 1 cycle.
  - Next edge: all outputs 0, state=IDLE, LFSR=16'hACE1.
  - Over 10 arm/deselect cycles, delay_ms sequence matches the model and never falls outside 2..9.
